// File: rtl/display_timing.sv
`default_nettype none
// ============================================================================
//  Module      : display_timing
//  Description : Raster timing generator with registered position, flags and
//                a sync/enable delay line matched to the renderer latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_timing #(
    parameter int H_ACTIVE   = 1280,
    parameter int H_FP       = 72,
    parameter int H_SYNC     = 128,
    parameter int H_BP       = 200,
    parameter int V_ACTIVE   = 800,
    parameter int V_FP       = 3,
    parameter int V_SYNC     = 6,
    parameter int V_BP       = 22,
    parameter bit H_POL      = 1'b0,
    parameter bit V_POL      = 1'b1,
    parameter int PIPE_DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [10:0] curr_x,
    output logic [9:0]  curr_y,
    output logic        active_area,
    output logic        line_start,
    output logic        frame_start,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] c_X_LAST   = 11'(c_H_TOTAL - 1);
    localparam logic [10:0] c_X_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] c_HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  c_Y_LAST   = 10'(c_V_TOTAL - 1);
    localparam logic [9:0]  c_Y_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  c_VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  c_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] r_x, w_x_next;
    logic [9:0]  r_y, w_y_next;
    logic        r_active, r_line, r_frame, r_hsync, r_vsync;
    logic        w_active, w_line, w_frame, w_hsync, w_vsync;

    always_comb begin
        w_x_next = r_x + 11'd1;
        w_y_next = r_y;
        if (r_x == c_X_LAST) begin
            w_x_next = '0;
            w_y_next = (r_y == c_Y_LAST) ? '0 : r_y + 10'd1;
        end
    end

    // Flags are decoded from the next position so that, once registered,
    // they line up with the position presented in the same cycle.
    always_comb begin
        w_active = (w_x_next < c_X_ACT) && (w_y_next < c_Y_ACT);
        w_line   = (w_x_next == '0);
        w_frame  = w_line && (w_y_next == '0);
        w_hsync  = ((w_x_next >= c_HS_START) && (w_x_next < c_HS_END)) ? H_POL : ~H_POL;
        w_vsync  = ((w_y_next >= c_VS_START) && (w_y_next < c_VS_END)) ? V_POL : ~V_POL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x      <= '0;
            r_y      <= '0;
            r_active <= 1'b1;
            r_line   <= 1'b1;
            r_frame  <= 1'b1;
            r_hsync  <= ~H_POL;
            r_vsync  <= ~V_POL;
        end else if (en) begin
            r_x      <= w_x_next;
            r_y      <= w_y_next;
            r_active <= w_active;
            r_line   <= w_line;
            r_frame  <= w_frame;
            r_hsync  <= w_hsync;
            r_vsync  <= w_vsync;
        end
    end

    assign curr_x      = r_x;
    assign curr_y      = r_y;
    assign active_area = r_active;
    assign line_start  = r_line;
    assign frame_start = r_frame;

    generate
        if (PIPE_DEPTH == 0) begin : g_bypass
            assign hsync_o = r_hsync;
            assign vsync_o = r_vsync;
            assign de_o    = r_active;
        end else begin : g_pipe
            logic [PIPE_DEPTH-1:0] r_hs_pipe, r_vs_pipe, r_de_pipe;
            logic [PIPE_DEPTH:0]   w_hs_chain, w_vs_chain, w_de_chain;

            assign w_hs_chain = {r_hs_pipe, r_hsync};
            assign w_vs_chain = {r_vs_pipe, r_vsync};
            assign w_de_chain = {r_de_pipe, r_active};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_hs_pipe <= {PIPE_DEPTH{~H_POL}};
                    r_vs_pipe <= {PIPE_DEPTH{~V_POL}};
                    r_de_pipe <= '0;
                end else if (en) begin
                    r_hs_pipe <= w_hs_chain[PIPE_DEPTH-1:0];
                    r_vs_pipe <= w_vs_chain[PIPE_DEPTH-1:0];
                    r_de_pipe <= w_de_chain[PIPE_DEPTH-1:0];
                end
            end

            assign hsync_o = r_hs_pipe[PIPE_DEPTH-1];
            assign vsync_o = r_vs_pipe[PIPE_DEPTH-1];
            assign de_o    = r_de_pipe[PIPE_DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_display_timing.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_timing
//  Description : Randomised scoreboard bench for display_timing on a small
//                raster; expectations come from an enabled-cycle count model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_timing;

    localparam int c_HA = 8, c_HF = 2, c_HS = 3, c_HB = 4;
    localparam int c_VA = 6, c_VF = 1, c_VS = 2, c_VB = 3;
    localparam int c_D  = 3;
    localparam bit c_HPOL = 1'b0, c_VPOL = 1'b1;
    localparam int c_HT = c_HA + c_HF + c_HS + c_HB;
    localparam int c_VT = c_VA + c_VF + c_VS + c_VB;
    localparam int c_F  = c_HT * c_VT;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic        act, ls, fs, hs, vs, de;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, en;
    logic [10:0] curr_x;
    logic [9:0]  curr_y;
    logic        active_area, line_start, frame_start, hsync_o, vsync_o, de_o;

    exp_t q[$];
    int   n_enabled = 0;
    int   vectors = 0;
    int   miscompares = 0;

    display_timing #(
        .H_ACTIVE(c_HA), .H_FP(c_HF), .H_SYNC(c_HS), .H_BP(c_HB),
        .V_ACTIVE(c_VA), .V_FP(c_VF), .V_SYNC(c_VS), .V_BP(c_VB),
        .H_POL(c_HPOL), .V_POL(c_VPOL), .PIPE_DEPTH(c_D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .curr_x(curr_x), .curr_y(curr_y),
        .active_area(active_area), .line_start(line_start), .frame_start(frame_start),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o)
    );

    always #5 clk = ~clk;

    // Position is simply the count of enabled cycles since reset, modulo a frame.
    function automatic exp_t model(input int n);
        exp_t e;
        int   p, x, y, pd, xd, yd;
        p = n % c_F;
        x = p % c_HT;
        y = p / c_HT;
        e.x   = 11'(x);
        e.y   = 10'(y);
        e.act = (x < c_HA) && (y < c_VA);
        e.ls  = (x == 0);
        e.fs  = (p == 0);
        if (n < c_D) begin
            e.hs = ~c_HPOL;
            e.vs = ~c_VPOL;
            e.de = 1'b0;
        end else begin
            pd = (n - c_D) % c_F;
            xd = pd % c_HT;
            yd = pd / c_HT;
            e.hs = (xd >= c_HA + c_HF && xd < c_HA + c_HF + c_HS) ? c_HPOL : ~c_HPOL;
            e.vs = (yd >= c_VA + c_VF && yd < c_VA + c_VF + c_VS) ? c_VPOL : ~c_VPOL;
            e.de = (xd < c_HA) && (yd < c_VA);
        end
        return e;
    endfunction

    // One clock: account for the edge just taken, then apply new inputs.
    task automatic step(input logic new_en, input logic new_rst_n);
        @(posedge clk);
        #1;
        if (!rst_n)  n_enabled = 0;
        else if (en) n_enabled++;
        en    = new_en;
        rst_n = new_rst_n;
        if (!rst_n) n_enabled = 0;
        q.push_back(model(n_enabled));
    endtask

    task automatic run_until(input int target);
        int guard = 0;
        while ((n_enabled % c_F) != target && guard < 2 * c_F) begin
            step(1'b1, 1'b1);
            guard++;
        end
        if (guard >= 2 * c_F) begin
            $display("FAIL run_until: position %0d not reached, got %0d", target, n_enabled % c_F);
            miscompares++;
            vectors++;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (curr_x !== e.x || curr_y !== e.y || active_area !== e.act ||
                    line_start !== e.ls || frame_start !== e.fs ||
                    hsync_o !== e.hs || vsync_o !== e.vs || de_o !== e.de) begin
                    miscompares++;
                    $display("FAIL timing @%0t: got x=%0d y=%0d act=%b ls=%b fs=%b hs=%b vs=%b de=%b, want x=%0d y=%0d act=%b ls=%b fs=%b hs=%b vs=%b de=%b",
                             $time, curr_x, curr_y, active_area, line_start, frame_start,
                             hsync_o, vsync_o, de_o, e.x, e.y, e.act, e.ls, e.fs, e.hs, e.vs, e.de);
                end
            end
        end
    end

    initial begin : timeout
        #500000;
        $display("FAIL timeout: simulation did not finish, miscompares=%0d", miscompares);
        $fatal(1);
    end

    initial begin : stimulus
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (2 * c_F) step(1'b1, 1'b1);

        for (int i = 0; i < 2500; i++) begin
            logic re, rr;
            re = ($urandom_range(0, 7) != 0);
            rr = ($urandom_range(0, 399) != 0);
            step(re, rr);
        end
        step(1'b1, 1'b1);

        // Freeze at the last position of a frame, then resume into (0,0).
        run_until(c_F - 2);
        step(1'b0, 1'b1);
        repeat (9) step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b1);

        // Asynchronous reset mid-frame, then restart from (1,0).
        run_until(4 * c_HT + 9);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (c_HT + 5) step(1'b1, 1'b1);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            $display("FAIL drain: %0d expected entries unchecked, want 0", q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_timing.md
DISPLAY_TIMING -- requirements
Module: display_timing

Interface
REQ-001 Parameter H_ACTIVE, default 1280, visible pixels per line.
REQ-002 Parameter H_FP, default 72, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 128, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 200, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 800, visible lines per frame.
REQ-006 Parameter V_FP, default 3, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 6, vertical sync width in lines.
REQ-008 Parameter V_BP, default 22, vertical back porch in lines.
REQ-009 Parameter H_POL, default 0, asserted level of hsync (0 = active-low).
REQ-010 Parameter V_POL, default 1, asserted level of vsync (1 = active-high).
REQ-011 Parameter PIPE_DEPTH, default 1, range 0..7, delay in cycles from curr_x/curr_y to the delayed sync/enable outputs; it matches the pixel renderer's latency.
REQ-012 clk  input  1  pixel clock; all state changes on its rising edge.
REQ-013 rst_n  input  1  reset, asynchronous and active-low.
REQ-014 en  input  1  advance enable; when low, timing freezes.
REQ-015 curr_x  output  11  current horizontal position, 0..H_TOTAL-1.
REQ-016 curr_y  output  10  current vertical position, 0..V_TOTAL-1.
REQ-017 active_area  output  1  high when curr_x < H_ACTIVE and curr_y < V_ACTIVE.
REQ-018 line_start  output  1  high when curr_x == 0.
REQ-019 frame_start  output  1  high when curr_x == 0 and curr_y == 0.
REQ-020 hsync_o, vsync_o, de_o  output  1 each  hsync, vsync and active_area delayed by PIPE_DEPTH cycles.

Function
REQ-021 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, which is 1680 by default; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, which is 831 by default.
REQ-022 All outputs shall be registered; no combinational path from any input to any output.
REQ-023 Each enabled cycle, curr_x shall increment by 1. At H_TOTAL-1 it shall wrap to 0 and curr_y shall increment by 1. At curr_y = V_TOTAL-1 with curr_x = H_TOTAL-1, both shall wrap to 0 in the same cycle.
REQ-024 Internal hsync shall equal H_POL when H_ACTIVE+H_FP <= curr_x < H_ACTIVE+H_FP+H_SYNC (1352..1479 by default), and ~H_POL otherwise.
REQ-025 Internal vsync shall equal V_POL when V_ACTIVE+V_FP <= curr_y < V_ACTIVE+V_FP+V_SYNC (803..808 by default), across the whole line, and ~V_POL otherwise.
REQ-026 active_area, line_start, frame_start and the internal syncs shall always be consistent with the curr_x/curr_y value presented in the same cycle.
REQ-027 hsync_o, vsync_o and de_o shall be a PIPE_DEPTH-stage shift of the internal hsync, vsync and active_area; PIPE_DEPTH = 0 passes them through in the same cycle.
REQ-028 When en is low, curr_x, curr_y, all flags and all pipeline stages shall hold their values. When en returns high, counting resumes from the held position with no skipped or repeated position.
REQ-029 Counters shall be wide enough for H_TOTAL-1 and V_TOTAL-1. Values >= H_TOTAL or >= V_TOTAL shall never be produced.

Reset
REQ-030 While rst_n is low: curr_x=0, curr_y=0, active_area=1, line_start=1, frame_start=1; internal hsync=~H_POL and vsync=~V_POL; every pipeline stage holds hsync_o=~H_POL, vsync_o=~V_POL, de_o=0.
REQ-031 The first enabled edge after rst_n deasserts shall present position (1,0). Reset asserted mid-frame shall return the block to the REQ-030 state immediately, without waiting for a clock edge.

Verification
REQ-032 Release reset, en=1, run 1,396,080 cycles -> curr_x/curr_y return to (0,0); frame_start=1 for exactly 1 cycle per frame; line_start=1 for exactly 831 cycles per frame.
REQ-033 Count asserted cycles per frame -> active_area = 1,024,000; hsync low exactly 128 cycles per line, starting at x=1352; vsync high for exactly lines 803..808.
REQ-034 PIPE_DEPTH=3 -> hsync_o, vsync_o and de_o equal the internal signals delayed by exactly 3 cycles; first 3 cycles after reset show the inactive values.
REQ-035 Drop en for 10 cycles at (1679,830) -> position holds at (1679,830); the next enabled cycle gives (0,0) with frame_start=1.
REQ-036 Assert rst_n low asynchronously at (700,400) -> outputs reach the REQ-030 values before the next clock edge; after release, the sequence restarts at (1,0).
REQ-037 Boundaries: at x=1279 -> active_area=1; at x=1280 -> active_area=0; at y=799 on row end -> the next line has active_area=0 for its entire width.
